// File: rtl/pc_stack_unit.sv
// Program counter and return-address stack sitting behind the control unit.
// Produces the next fetch address each cycle and tracks CALL/RET nesting.
module pc_stack_unit #(
    parameter int PC_W  = 10,
    parameter int DEPTH = 8,
    parameter int SP_W  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            s_inc,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] dest,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] ret_top,
    output logic [SP_W-1:0] sp,
    output logic            empty,
    output logic            full,
    output logic            ovf_err,
    output logic            unf_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(DEPTH);
    localparam logic [PC_W-1:0] PC_ONE  = PC_W'(1);

    logic [PC_W-1:0] pc_q, pc_d;
    logic [SP_W-1:0] sp_q, sp_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic [PC_W-1:0] stk_q [DEPTH];

    logic [PC_W-1:0] pc_inc;
    logic [AW-1:0]   top_idx;
    logic            wr_en;
    logic [AW-1:0]   wr_idx;
    logic            is_empty, is_full;

    assign pc_inc   = pc_q + PC_ONE;
    assign top_idx  = AW'(sp_q - SP_ONE);
    assign is_empty = (sp_q == '0);
    assign is_full  = (sp_q == SP_FULL);

    always_comb begin
        pc_d   = pc_q;
        sp_d   = sp_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        wr_en  = 1'b0;
        wr_idx = top_idx;
        if (en) begin
            if (push && pop && !is_empty) begin
                // Tail call: replace the current return address in place.
                wr_en  = 1'b1;
                wr_idx = top_idx;
                pc_d   = dest;
            end else if (push) begin
                pc_d = dest;
                if (is_full) begin
                    ovf_d = 1'b1;
                end else begin
                    wr_en  = 1'b1;
                    wr_idx = sp_q[AW-1:0];
                    sp_d   = sp_q + SP_ONE;
                end
            end else if (pop) begin
                if (is_empty) begin
                    pc_d  = pc_inc;
                    unf_d = 1'b1;
                end else begin
                    pc_d = stk_q[top_idx];
                    sp_d = sp_q - SP_ONE;
                end
            end else begin
                pc_d = s_inc ? pc_inc : dest;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q  <= '0;
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                stk_q[i] <= '0;
            end
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
            if (wr_en) begin
                stk_q[wr_idx] <= pc_inc;
            end
        end
    end

    assign pc      = pc_q;
    assign sp      = sp_q;
    assign empty   = is_empty;
    assign full    = is_full;
    assign ovf_err = ovf_q;
    assign unf_err = unf_q;
    assign ret_top = is_empty ? '0 : stk_q[top_idx];

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit: sequencing, jumps, CALL/RET nesting,
// overflow/underflow flags, tail calls and asynchronous reset.
module tb_pc_stack_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       en, s_inc, push, pop;
    logic [9:0] dest;
    logic [9:0] pc, ret_top;
    logic [3:0] sp;
    logic       empty, full, ovf_err, unf_err;

    int n_cmp = 0;
    int n_bad = 0;
    logic [9:0] ret_exp [8];

    pc_stack_unit dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .s_inc  (s_inc),
        .push   (push),
        .pop    (pop),
        .dest   (dest),
        .pc     (pc),
        .ret_top(ret_top),
        .sp     (sp),
        .empty  (empty),
        .full   (full),
        .ovf_err(ovf_err),
        .unf_err(unf_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic i_s, input logic i_push,
                        input logic i_pop, input logic [9:0] i_dest);
        s_inc = i_s;
        push  = i_push;
        pop   = i_pop;
        dest  = i_dest;
        @(posedge clk);
        #1;
        s_inc = 1'b1;
        push  = 1'b0;
        pop   = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        en    = 1'b0;
        s_inc = 1'b1;
        push  = 1'b0;
        pop   = 1'b0;
        dest  = '0;
        #1;
        check("rst_pc", pc, 0);
        check("rst_sp", sp, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_ovf", ovf_err, 0);
        check("rst_unf", unf_err, 0);
        check("rst_top", ret_top, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        en    = 1'b1;

        for (int i = 1; i <= 4; i++) begin
            step(1, 0, 0, 10'h000);
            check("seq_pc", pc, i);
        end
        check("seq_sp", sp, 0);
        check("seq_empty", empty, 1);

        step(1, 0, 0, 10'h000);
        check("pc5", pc, 5);
        step(0, 0, 0, 10'h120);
        check("jump", pc, 10'h120);
        step(0, 0, 0, 10'h3FF);
        step(1, 0, 0, 10'h000);
        check("wrap", pc, 10'h000);

        en = 1'b0;
        step(0, 1, 0, 10'h055);
        check("hold_pc", pc, 0);
        check("hold_sp", sp, 0);
        en = 1'b1;

        step(0, 0, 0, 10'h010);
        step(0, 1, 0, 10'h200);
        check("call_pc", pc, 10'h200);
        check("call_sp", sp, 1);
        check("call_top", ret_top, 10'h011);
        step(0, 0, 1, 10'h000);
        check("ret_pc", pc, 10'h011);
        check("ret_sp", sp, 0);
        check("ret_empty", empty, 1);

        step(0, 0, 0, 10'h000);
        for (int i = 0; i < 8; i++) begin
            ret_exp[i] = (i == 0) ? 10'h001 : 10'(10'h042 + 16 * (i - 1));
            step(0, 1, 0, 10'(10'h040 + 16 * i));
            check("nest_pc", pc, 10'h040 + 16 * i);
            check("nest_sp", sp, i + 1);
            check("nest_top", ret_top, ret_exp[i]);
            if (i < 7) step(1, 0, 0, 10'h000);
        end
        check("nest_full", full, 1);
        step(0, 1, 0, 10'h300);
        check("ovf_pc", pc, 10'h300);
        check("ovf_sp", sp, 8);
        check("ovf_flag", ovf_err, 1);
        check("ovf_top", ret_top, ret_exp[7]);
        for (int k = 7; k >= 0; k--) begin
            step(0, 0, 1, 10'h000);
            check("unwind_pc", pc, ret_exp[k]);
            check("unwind_sp", sp, k);
        end
        check("unwind_empty", empty, 1);
        check("unwind_unf", unf_err, 0);
        check("ovf_sticky", ovf_err, 1);

        step(0, 0, 0, 10'h050);
        step(0, 0, 1, 10'h000);
        check("unf_pc", pc, 10'h051);
        check("unf_flag", unf_err, 1);
        check("unf_sp", sp, 0);
        step(1, 0, 0, 10'h000);
        step(1, 0, 0, 10'h000);
        check("unf_sticky", unf_err, 1);

        step(0, 0, 0, 10'h020);
        step(0, 1, 0, 10'h100);
        check("tc_call_sp", sp, 1);
        check("tc_call_top", ret_top, 10'h021);
        step(0, 1, 1, 10'h180);
        check("tc_pc", pc, 10'h180);
        check("tc_sp", sp, 1);
        check("tc_top", ret_top, 10'h101);
        step(0, 0, 1, 10'h000);
        check("tc_ret", pc, 10'h101);
        step(0, 1, 1, 10'h060);
        check("tc0_pc", pc, 10'h060);
        check("tc0_sp", sp, 1);
        check("tc0_top", ret_top, 10'h102);

        #2;
        reset = 1'b0;
        #1;
        check("arst_pc", pc, 0);
        check("arst_sp", sp, 0);
        check("arst_ovf", ovf_err, 0);
        check("arst_unf", unf_err, 0);
        check("arst_empty", empty, 1);
        check("arst_top", ret_top, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
